// File: rtl/opl3_i2s_tx.sv
// opl3_i2s_tx
// Stereo I2S transmitter fed by the channel accumulator. Incoming stereo
// samples are parked in a small FIFO. BCLK and LRCLK are derived from clk by
// a divider and a bit counter. At each frame start the FIFO head is popped
// into the held L/R registers. Those registers are then shifted out MSB first,
// with the standard one-bit I2S delay.
//
// Build option: define OPL3_I2S_UNDERRUN_MUTE_EN to clear the held samples
// when a frame starts with an empty FIFO, so that frame is silent. Without
// the macro, the last sample pair is repeated on underrun.

`default_nettype none

module opl3_i2s_tx #(
    parameter int SAMPLE_WIDTH  = 16,
    parameter int SLOT_BITS     = 32,
    parameter int BCLK_HALF_DIV = 4,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          channel_valid,
    input  logic [SAMPLE_WIDTH-1:0]       channel_l,
    input  logic [SAMPLE_WIDTH-1:0]       channel_r,
    output logic                          i2s_bclk,
    output logic                          i2s_lrclk,
    output logic                          i2s_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic                          underrun
);

    // ------------------------------------------------------------------
    // Derived sizes and constants
    // ------------------------------------------------------------------
    localparam int DIV_W   = $clog2(BCLK_HALF_DIV);
    localparam int BIT_W   = $clog2(2 * SLOT_BITS);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int LVL_W   = PTR_W + 1;
    localparam int ENTRY_W = 2 * SAMPLE_WIDTH;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_HALF_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOT_BITS - 1);
    localparam logic [BIT_W-1:0] SLOT_B   = BIT_W'(SLOT_BITS);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

    // Reject parameter sets the framing cannot represent.
    generate
        if (SLOT_BITS < SAMPLE_WIDTH + 1) begin : g_bad_slot
            $error("opl3_i2s_tx: SLOT_BITS must be >= SAMPLE_WIDTH+1");
        end
        if (BCLK_HALF_DIV < 2) begin : g_bad_div
            $error("opl3_i2s_tx: BCLK_HALF_DIV must be >= 2");
        end
        if ((FIFO_DEPTH < 2) || ((1 << PTR_W) != FIFO_DEPTH)) begin : g_bad_depth
            $error("opl3_i2s_tx: FIFO_DEPTH must be a power of 2 and >= 2");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [DIV_W-1:0]        r_div_cnt;
    logic                    r_bclk;
    logic [BIT_W-1:0]        r_bit_cnt;
    logic                    r_lrclk;
    logic                    r_data;
    logic [SAMPLE_WIDTH-1:0] r_held_l;
    logic [SAMPLE_WIDTH-1:0] r_held_r;
    logic [ENTRY_W-1:0]      r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        r_wr_ptr;
    logic [PTR_W-1:0]        r_rd_ptr;
    logic [LVL_W-1:0]        r_level;
    logic                    r_overflow;
    logic                    r_underrun;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic                    w_div_wrap;
    logic                    w_fall;
    logic                    w_frame_start;
    logic [BIT_W-1:0]        w_bit_next;
    logic                    w_right_slot;
    logic [BIT_W-1:0]        w_slot_pos;
    logic [SAMPLE_WIDTH-1:0] w_sample;
    logic [SAMPLE_WIDTH-1:0] w_bit_hit;
    logic                    w_data_bit;
    logic                    w_empty;
    logic                    w_full;
    logic                    w_pop;
    logic                    w_push;
    logic                    w_drop;
    logic [ENTRY_W-1:0]      w_head;

    assign w_div_wrap    = (r_div_cnt == DIV_LAST);
    // A fall event is the divider wrap that takes BCLK from 1 to 0.
    assign w_fall        = w_div_wrap && r_bclk;
    assign w_bit_next    = (r_bit_cnt == BIT_LAST) ? '0 : r_bit_cnt + 1'b1;
    assign w_frame_start = w_fall && (r_bit_cnt == BIT_LAST);

    // Position of the upcoming bit within its slot, and the slot's sample.
    assign w_right_slot  = (w_bit_next >= SLOT_B);
    assign w_slot_pos    = w_right_slot ? (w_bit_next - SLOT_B) : w_bit_next;
    assign w_sample      = w_right_slot ? r_held_r : r_held_l;

    // Slot position k (1..SAMPLE_WIDTH) selects sample bit SAMPLE_WIDTH-k.
    // Position 0 (the I2S delay bit) and the padding positions match no
    // entry here, so they transmit 0.
    generate
        for (genvar gi = 0; gi < SAMPLE_WIDTH; gi++) begin : g_bit_sel
            assign w_bit_hit[gi] = (w_slot_pos == BIT_W'(SAMPLE_WIDTH - gi));
        end
    endgenerate
    assign w_data_bit = |(w_bit_hit & w_sample);

    // FIFO control. The pop decision only looks at the current level, so a
    // write into an empty FIFO in a frame-start cycle is never bypassed.
    // A pop frees a slot in the same cycle, so a full FIFO still accepts a
    // write when a pop happens alongside it.
    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == LVL_FULL);
    assign w_pop   = w_frame_start && !w_empty;
    assign w_push  = channel_valid && (!w_full || w_pop);
    assign w_drop  = channel_valid && w_full && !w_pop;
    assign w_head  = r_mem[r_rd_ptr];

    // ------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------

    // Half-period divider; BCLK toggles every time the divider wraps.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div_cnt <= '0;
            r_bclk    <= 1'b0;
        end else if (w_div_wrap) begin
            r_div_cnt <= '0;
            r_bclk    <= ~r_bclk;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

    // Bit counter, word select and serial data all move only on fall events.
    // This keeps them stable across the rising BCLK edge the DAC samples on.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bit_cnt <= BIT_LAST;
            r_lrclk   <= 1'b1;
            r_data    <= 1'b0;
        end else if (w_fall) begin
            r_bit_cnt <= w_bit_next;
            r_data    <= w_data_bit;
            if (w_bit_next == '0) begin
                r_lrclk <= 1'b0;
            end else if (w_bit_next == SLOT_B) begin
                r_lrclk <= 1'b1;
            end
        end
    end

    // Sample storage. The FIFO is small enough for distributed RAM, and the
    // level counter gates every read, so this storage needs no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {channel_l, channel_r};
        end
    end

    // FIFO pointers, level, and the one-cycle overflow/underrun pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_level    <= r_level + LVL_W'(w_push) - LVL_W'(w_pop);
            r_overflow <= w_drop;
            r_underrun <= w_frame_start && w_empty;
        end
    end

    // Held frame samples are loaded from the FIFO head at frame start.
    // On underrun they are either muted or kept, depending on the build.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_held_l <= '0;
            r_held_r <= '0;
        end else if (w_pop) begin
            r_held_l <= w_head[ENTRY_W-1:SAMPLE_WIDTH];
            r_held_r <= w_head[SAMPLE_WIDTH-1:0];
        end
`ifdef OPL3_I2S_UNDERRUN_MUTE_EN
        else if (w_frame_start) begin
            r_held_l <= '0;
            r_held_r <= '0;
        end
`endif
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign i2s_bclk   = r_bclk;
    assign i2s_lrclk  = r_lrclk;
    assign i2s_data   = r_data;
    assign fifo_level = r_level;
    assign overflow   = r_overflow;
    assign underrun   = r_underrun;

endmodule

`default_nettype wire

// File: tb/tb_opl3_i2s_tx.sv
// Testbench for opl3_i2s_tx: directed scenarios plus randomized traffic.
// The reference model works from the clock count since reset release and
// a sample queue.
module tb_opl3_i2s_tx;

    localparam int SW        = 16;
    localparam int S         = 32;
    localparam int H         = 2;
    localparam int D         = 4;
    localparam int FALL_CYC  = 2 * H;
    localparam int FRAME_CYC = 2 * S * FALL_CYC;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          channel_valid = 1'b0;
    logic [SW-1:0] channel_l = '0;
    logic [SW-1:0] channel_r = '0;
    logic          i2s_bclk;
    logic          i2s_lrclk;
    logic          i2s_data;
    logic [2:0]    fifo_level;
    logic          overflow;
    logic          underrun;

    always #5 clk = ~clk;

    opl3_i2s_tx #(
        .SAMPLE_WIDTH (SW),
        .SLOT_BITS    (S),
        .BCLK_HALF_DIV(H),
        .FIFO_DEPTH   (D)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .channel_valid(channel_valid),
        .channel_l    (channel_l),
        .channel_r    (channel_r),
        .i2s_bclk     (i2s_bclk),
        .i2s_lrclk    (i2s_lrclk),
        .i2s_data     (i2s_data),
        .fifo_level   (fifo_level),
        .overflow     (overflow),
        .underrun     (underrun)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int unsigned     c = 0;          // rising edges since reset release
    logic [2*SW-1:0] q[$];           // FIFO contents {L,R}
    logic [SW-1:0]   m_l = '0;
    logic [SW-1:0]   m_r = '0;
    logic            m_ovf = 1'b0;
    logic            m_und = 1'b0;
    logic [63:0]     cap = '0;
    logic [63:0]     obs[$];         // observed frames since release
    int unsigned     ev, b, k;
    logic            e_bclk, e_lr, e_d;
    logic [SW-1:0]   smp;

    always @(posedge clk) begin
        if (!reset_n) begin
            c = 0;
            q.delete();
            obs.delete();
            m_l = '0;
            m_r = '0;
            m_ovf = 1'b0;
            m_und = 1'b0;
        end else begin
            c = c + 1;
            m_ovf = 1'b0;
            m_und = 1'b0;
            if (c % FRAME_CYC == FALL_CYC) begin
                if (q.size() != 0) begin
                    {m_l, m_r} = q.pop_front();
                end else begin
                    m_und = 1'b1;
`ifdef OPL3_I2S_UNDERRUN_MUTE_EN
                    m_l = '0;
                    m_r = '0;
`endif
                end
            end
            if (channel_valid) begin
                if (q.size() < D) q.push_back({channel_l, channel_r});
                else m_ovf = 1'b1;
            end
        end
        #1;
        e_bclk = ((c / H) % 2) == 1;
        ev = c / FALL_CYC;
        if (ev == 0) begin
            e_lr = 1'b1;
            e_d  = 1'b0;
        end else begin
            b    = (ev - 1) % (2 * S);
            e_lr = (b >= S);
            k    = b % S;
            smp  = (b < S) ? m_l : m_r;
            e_d  = (k >= 1 && k <= SW) ? smp[SW-k] : 1'b0;
        end
        chk("bclk",     64'(i2s_bclk),   64'(e_bclk));
        chk("lrclk",    64'(i2s_lrclk),  64'(e_lr));
        chk("data",     64'(i2s_data),   64'(e_d));
        chk("level",    64'(fifo_level), 64'(q.size()));
        chk("overflow", 64'(overflow),   64'(m_ovf));
        chk("underrun", 64'(underrun),   64'(m_und));
        if (reset_n && ev > 0 && (c % FALL_CYC) == 0) begin
            cap = {cap[62:0], i2s_data};
            if ((ev - 1) % (2 * S) == 2 * S - 1) obs.push_back(cap);
        end
    end

    // ---------------- helpers ----------------
    function automatic logic [63:0] frame_of(input logic [31:0] lr);
        return {1'b0, lr[31:16], 15'b0, 1'b0, lr[15:0], 15'b0};
    endfunction

    task automatic chk_frame(input string name, input int idx, input logic [63:0] exp);
        if (obs.size() > idx) begin
            chk(name, obs[idx], exp);
        end else begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: frame %0d missing, got %0d frames required %0d", name, idx, obs.size(), idx + 1);
        end
    endtask

    task automatic wait_c(input int unsigned n);
        int guard = 0;
        while (c < n && guard < 4000) begin
            @(negedge clk);
            guard++;
        end
        if (c < n) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_c: got cycle %0d required %0d", c, n);
        end
    endtask

    task automatic send(input logic [31:0] lr);
        channel_valid = 1'b1;
        {channel_l, channel_r} = lr;
        @(negedge clk);
        channel_valid = 1'b0;
    endtask

    task automatic do_reset(input int n);
        reset_n = 1'b0;
        repeat (n) @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] s [5];
        logic [31:0] snew;
        int unsigned r;
        int burst;
        burst = 0;

        // Reset values, then the first frame with one sample pair.
        repeat (5) @(negedge clk);
        chk("t1_rst_bclk",  64'(i2s_bclk),   64'd0);
        chk("t1_rst_lrclk", 64'(i2s_lrclk),  64'd1);
        chk("t1_rst_data",  64'(i2s_data),   64'd0);
        chk("t1_rst_level", 64'(fifo_level), 64'd0);
        reset_n = 1'b1;
        send(32'h8001_7FFE);
        wait_c(2);
        chk("t1_bclk_rise", 64'(i2s_bclk),   64'd1);
        chk("t2_level1",    64'(fifo_level), 64'd1);
        wait_c(3);
        chk("t1_lrclk_c3",  64'(i2s_lrclk),  64'd1);
        wait_c(4);
        chk("t1_lrclk_c4",  64'(i2s_lrclk),  64'd0);
        chk("t1_bclk_c4",   64'(i2s_bclk),   64'd0);
        chk("t2_pop_level", 64'(fifo_level), 64'd0);
        wait_c(FRAME_CYC + 1);
        chk_frame("t2_frame0", 0, 64'h40008000_3FFF0000);
        wait_c(FRAME_CYC + FALL_CYC);
        chk("t2_underrun_f1", 64'(underrun), 64'd1);

        // Underrun behaviour on the second frame.
        do_reset(3);
        send(32'h1234_5678);
        wait_c(FRAME_CYC + FALL_CYC);
        chk("t3_underrun", 64'(underrun), 64'd1);
        wait_c(2 * FRAME_CYC + 1);
        chk_frame("t3_frame0", 0, 64'h091A0000_2B3C0000);
`ifdef OPL3_I2S_UNDERRUN_MUTE_EN
        chk_frame("t3_frame1", 1, 64'h0);
`else
        chk_frame("t3_frame1", 1, 64'h091A0000_2B3C0000);
`endif

        // Overflow on the fifth back-to-back write, then pop plus write while full.
        do_reset(3);
        wait_c(10);
        for (int i = 0; i < 5; i++) begin
            s[i] = $urandom();
            s[i][31:28] = 4'(i);
        end
        for (int i = 0; i < 5; i++) begin
            channel_valid = 1'b1;
            {channel_l, channel_r} = s[i];
            @(negedge clk);
            chk("t4_level", 64'(fifo_level), (i < 4) ? 64'(i + 1) : 64'd4);
            chk("t4_overflow", 64'(overflow), (i == 4) ? 64'd1 : 64'd0);
        end
        channel_valid = 1'b0;
        wait_c(FRAME_CYC + FALL_CYC - 1);
        snew = $urandom();
        snew[31:28] = 4'hF;
        send(snew);
        chk("t5_overflow", 64'(overflow),   64'd0);
        chk("t5_level",    64'(fifo_level), 64'd4);
        wait_c(6 * FRAME_CYC + 1);
        for (int i = 0; i < 4; i++) chk_frame("t4_frame", i + 1, frame_of(s[i]));
        chk_frame("t5_frame5", 5, frame_of(snew));
        for (int f = 1; f < 6; f++) begin
            if (obs.size() > f) begin
                n_checks++;
                if (obs[f] === frame_of(s[4])) begin
                    n_fail++;
                    $display("FAIL t4_dropped_absent: frame %0d got %h required anything else", f, obs[f]);
                end
            end
        end

        // Reset during bit 10 of a left slot, with three samples queued.
        wait_c(6 * FRAME_CYC + FALL_CYC);
        send($urandom());
        send($urandom());
        send($urandom());
        wait_c(6 * FRAME_CYC + FALL_CYC + 10 * FALL_CYC + 2);
        chk("t6_level_pre", 64'(fifo_level), 64'd3);
        chk("t6_lrclk_pre", 64'(i2s_lrclk),  64'd0);
        chk("t6_bclk_pre",  64'(i2s_bclk),   64'd1);
        reset_n = 1'b0;
        #1;
        chk("t6_rst_bclk",     64'(i2s_bclk),   64'd0);
        chk("t6_rst_lrclk",    64'(i2s_lrclk),  64'd1);
        chk("t6_rst_data",     64'(i2s_data),   64'd0);
        chk("t6_rst_level",    64'(fifo_level), 64'd0);
        chk("t6_rst_overflow", 64'(overflow),   64'd0);
        chk("t6_rst_underrun", 64'(underrun),   64'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        wait_c(FALL_CYC);
        chk("t6_underrun", 64'(underrun),   64'd1);
        chk("t6_level",    64'(fifo_level), 64'd0);

        // Randomized traffic, including writes aimed at frame-start cycles and a mid-run reset.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            r = $urandom_range(0, 999);
            if (cyc == 1500) reset_n = 1'b0;
            if (cyc == 1503) reset_n = 1'b1;
            if (burst > 0) begin
                channel_valid = 1'b1;
                burst--;
            end else if ((c % FRAME_CYC) == FALL_CYC - 1 && r < 500) begin
                channel_valid = 1'b1;
            end else if (r < 8) begin
                channel_valid = 1'b1;
            end else if (r == 8) begin
                channel_valid = 1'b1;
                burst = 5;
            end else begin
                channel_valid = 1'b0;
            end
            channel_l = SW'($urandom());
            channel_r = SW'($urandom());
            @(negedge clk);
        end
        channel_valid = 1'b0;
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
